data_mem_responder: RTL and testbench
=====================================

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024, word capacity of the array, a power of 2.
REQ-002 SHALL have parameter BASE_ADDR, default 32'h0000_1000, byte address of word 0.
REQ-003 SHALL have parameter WAIT_CYCLES, default 2, extra access wait states, range 0-15.
REQ-004 SHALL have port clk input 1: clock, all state changes on its rising edge.
REQ-005 SHALL have port reset input 1: reset, asynchronous, active-high.
REQ-006 SHALL have port data_address input 32: CPU byte address.
REQ-007 SHALL have port data_read input 1: CPU read request.
REQ-008 SHALL have port data_write input 1: CPU write request.
REQ-009 SHALL have port data_byteenable input 4: write lane mask, bit i covers bits [8i+7:8i].
REQ-010 SHALL have port data_writedata input 32: write data.
REQ-011 SHALL have port data_readdata output 32: read data.
REQ-012 SHALL have port stall output 1: high means the CPU holds its request and does not advance (drives CPU clk_enable low).
REQ-013 SHALL have port err output 1: one-cycle error pulse.

Function
REQ-014 SHALL implement a 3-state FSM: IDLE, BUSY, DONE.
REQ-015 stall SHALL be combinational: 1 when (state==IDLE and (data_read or data_write)) or state==BUSY; else 0.
REQ-016 In IDLE with a request at a clock edge, SHALL capture address, byteenable, writedata and operation, load wait counter with WAIT_CYCLES, and go to BUSY.
REQ-017 If data_read and data_write are both high in IDLE, SHALL treat the request as a write and pulse err in the following cycle.
REQ-018 In BUSY, SHALL decrement the counter each edge while it is nonzero, and go to DONE on the edge where it is 0.
REQ-019 Total stall-high duration per access SHALL be exactly WAIT_CYCLES+2 cycles, followed by one DONE cycle with stall=0.
REQ-020 Request inputs changing during BUSY SHALL be ignored; only captured values are used.
REQ-021 On the BUSY->DONE edge, a write SHALL update only the enabled byte lanes of the addressed word.
REQ-022 On the BUSY->DONE edge, a read SHALL load data_readdata with the full addressed word, ignoring byteenable.
REQ-023 data_readdata SHALL hold its value until the next completed read, and SHALL be unchanged by writes.
REQ-024 DONE SHALL go to IDLE on the next edge unconditionally; a request present in DONE is not accepted until IDLE.
REQ-025 Word index SHALL be (address - BASE_ADDR)>>2, with address[1:0] ignored.
REQ-026 An address below BASE_ADDR or at/above BASE_ADDR+4*DEPTH_WORDS is out of range.
REQ-027 Out-of-range write: SHALL leave the array unchanged and pulse err in the DONE cycle.
REQ-028 Out-of-range read: SHALL load data_readdata with 0 and pulse err in the DONE cycle.
REQ-029 err SHALL be high for exactly one cycle per faulting access.
REQ-030 Address arithmetic SHALL be 32-bit unsigned with no wrap-around; the range check uses the unwrapped comparison.
REQ-031 A write with byteenable 4'b0000 SHALL complete normally, with the full stall sequence and no array change.

Reset
REQ-032 While reset is high: state=IDLE, counter=0, data_readdata=0, err=0, stall=0.
REQ-033 Reset asserted mid-access SHALL abort the access: no array write and no readdata update.
REQ-034 Array contents SHALL NOT be cleared by reset.

Verification
REQ-035 WAIT_CYCLES=2: write 0xDEADBEEF to 0x1000 with be=4'hF, then read 0x1000 -> stall high 4 cycles each, data_readdata=0xDEADBEEF in the DONE cycle.
REQ-036 After REQ-035, write 0x000000AA to 0x1000 with be=4'b0001, then read -> 0xDEADBEAA.
REQ-037 Read 0x0FFC and read 0x1000+4*1024 -> data_readdata=0, err pulse 1 cycle each, stall sequence unchanged.
REQ-038 Write 0x12345678 to 0x1004; change data_address/data_writedata during BUSY; read 0x1004 -> 0x12345678.
REQ-039 Start a write of 0xFFFFFFFF to 0x1008 (previously 0x0); assert reset during BUSY -> FSM returns to IDLE, stall=0; a later read of 0x1008 returns 0x00000000.
REQ-040 WAIT_CYCLES=0: back-to-back reads driven by CPU model -> stall high 2 cycles, 1 DONE cycle, next request accepted only from IDLE.

Source files
------------

// File: rtl/data_mem_responder.sv
// Wait-stated data memory slave for the CPU data port.
// Stalls the CPU for WAIT_CYCLES+2 cycles, then completes in a DONE cycle.
module data_mem_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_1000,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] data_address,
    input  logic        data_read,
    input  logic        data_write,
    input  logic [3:0]  data_byteenable,
    input  logic [31:0] data_writedata,
    output logic [31:0] data_readdata,
    output logic        stall,
    output logic        err
);

    localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);
    localparam logic [32:0] BASE_EXT = {1'b0, BASE_ADDR};
    localparam logic [32:0] LIMIT_EXT =
        BASE_EXT + (33'(DEPTH_WORDS) << 2);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t state;
    logic [3:0] wait_cnt;

    logic [31:0] cap_addr;
    logic [3:0]  cap_be;
    logic [31:0] cap_wdata;
    logic        cap_write;
    logic        cap_conflict;

    logic [31:0] mem [DEPTH_WORDS];

    logic             in_range;
    logic [IDX_W-1:0] word_idx;
    logic             complete;
    logic             req;

    assign req = data_read || data_write;

    // Range check in 33 bits so the top of the map never wraps to zero.
    assign in_range = ({1'b0, cap_addr} >= BASE_EXT) &&
                      ({1'b0, cap_addr} <  LIMIT_EXT);

    assign word_idx = IDX_W'((cap_addr - BASE_ADDR) >> 2);

    assign complete = (state == BUSY) && (wait_cnt == 4'd0);

    // CPU is held while a request waits in IDLE or the access is in BUSY.
    assign stall = !reset &&
                   (((state == IDLE) && req) || (state == BUSY));

    // Access sequencer: capture, count wait states, complete, return.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            wait_cnt      <= 4'd0;
            data_readdata <= 32'd0;
            err           <= 1'b0;
            cap_addr      <= 32'd0;
            cap_be        <= 4'd0;
            cap_wdata     <= 32'd0;
            cap_write     <= 1'b0;
            cap_conflict  <= 1'b0;
        end else begin
            err <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (req) begin
                        cap_addr     <= data_address;
                        cap_be       <= data_byteenable;
                        cap_wdata    <= data_writedata;
                        cap_write    <= data_write;
                        cap_conflict <= data_read && data_write;
                        wait_cnt     <= WAIT_LD;
                        err          <= data_read && data_write;
                        state        <= BUSY;
                    end
                end
                BUSY: begin
                    if (wait_cnt != 4'd0) begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end else begin
                        state <= DONE;
                        if (!cap_write) begin
                            data_readdata <= in_range ? mem[word_idx]
                                                      : 32'd0;
                        end
                        // A conflicting request already reported its fault.
                        err <= !in_range && !cap_conflict;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Lane-masked array update on completion; contents survive reset.
    always_ff @(posedge clk) begin
        if (complete && cap_write && in_range) begin
            for (int i = 0; i < 4; i++) begin
                if (cap_be[i]) begin
                    mem[word_idx][8*i +: 8] <= cap_wdata[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder.
// Instance a uses WAIT_CYCLES=2, instance b uses WAIT_CYCLES=0.
module tb_data_mem_responder;

    logic        clk;
    logic        reset;
    logic        sel;
    logic [31:0] addr;
    logic        rd;
    logic        wr;
    logic [3:0]  be;
    logic [31:0] wdata;

    logic [31:0] rdata_a;
    logic        stall_a;
    logic        err_a;
    logic [31:0] rdata_b;
    logic        stall_b;
    logic        err_b;

    logic [31:0] cur_rdata;
    logic        cur_stall;
    logic        cur_err;

    int total;
    int bad;

    int          sc;
    int          ec;
    logic [31:0] rv;

    data_mem_responder #(
        .DEPTH_WORDS(1024),
        .BASE_ADDR  (32'h0000_1000),
        .WAIT_CYCLES(2)
    ) dut_a (
        .clk            (clk),
        .reset          (reset),
        .data_address   (addr),
        .data_read      (rd && !sel),
        .data_write     (wr && !sel),
        .data_byteenable(be),
        .data_writedata (wdata),
        .data_readdata  (rdata_a),
        .stall          (stall_a),
        .err            (err_a)
    );

    data_mem_responder #(
        .DEPTH_WORDS(1024),
        .BASE_ADDR  (32'h0000_1000),
        .WAIT_CYCLES(0)
    ) dut_b (
        .clk            (clk),
        .reset          (reset),
        .data_address   (addr),
        .data_read      (rd && sel),
        .data_write     (wr && sel),
        .data_byteenable(be),
        .data_writedata (wdata),
        .data_readdata  (rdata_b),
        .stall          (stall_b),
        .err            (err_b)
    );

    assign cur_rdata = sel ? rdata_b : rdata_a;
    assign cur_stall = sel ? stall_b : stall_a;
    assign cur_err   = sel ? err_b   : err_a;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [31:0] obs,
                         input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // CPU model: present request, hold while stalled, drop after DONE.
    task automatic access(input logic        is_wr,
                          input logic        is_rd,
                          input logic [31:0] a,
                          input logic [3:0]  b,
                          input logic [31:0] d,
                          input bit          scramble,
                          output int         n_stall,
                          output int         n_err,
                          output logic [31:0] r);
        bit done;
        done    = 1'b0;
        n_stall = 0;
        n_err   = 0;
        r       = 32'hxxxx_xxxx;
        @(negedge clk);
        addr  = a;
        be    = b;
        wdata = d;
        wr    = is_wr;
        rd    = is_rd;
        for (int i = 0; i < 40; i++) begin
            #1;
            if (cur_err) n_err++;
            if (!cur_stall) begin
                r    = cur_rdata;
                done = 1'b1;
                break;
            end
            n_stall++;
            @(negedge clk);
            if (scramble) begin
                addr  = 32'h0000_1000;
                wdata = 32'h0;
                be    = 4'hF;
            end
        end
        check("timeout", {31'd0, done}, 32'd1);
        rd = 1'b0;
        wr = 1'b0;
        @(negedge clk);
        #1;
        if (cur_err) n_err++;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        sel   = 1'b0;
        addr  = 32'h0;
        rd    = 1'b0;
        wr    = 1'b0;
        be    = 4'h0;
        wdata = 32'h0;
        reset = 1'b1;

        @(negedge clk);
        rd = 1'b1;
        #1;
        check("rst_stall_a", {31'd0, stall_a}, 32'd0);
        check("rst_err_a", {31'd0, err_a}, 32'd0);
        check("rst_rdata_a", rdata_a, 32'd0);
        check("rst_rdata_b", rdata_b, 32'd0);
        rd = 1'b0;
        @(negedge clk);
        reset = 1'b0;

        access(1, 0, 32'h1000, 4'hF, 32'hDEADBEEF, 0, sc, ec, rv);
        check("wr1_stall", sc, 4);
        check("wr1_err", ec, 0);
        access(0, 1, 32'h1000, 4'h0, 32'h0, 0, sc, ec, rv);
        check("rd1_stall", sc, 4);
        check("rd1_data", rv, 32'hDEADBEEF);
        check("rd1_err", ec, 0);

        access(1, 0, 32'h1000, 4'b0001, 32'h000000AA, 0, sc, ec, rv);
        check("wr2_hold_rdata", rv, 32'hDEADBEEF);
        access(0, 1, 32'h1000, 4'h0, 32'h0, 0, sc, ec, rv);
        check("rd2_lane", rv, 32'hDEADBEAA);

        access(0, 1, 32'h0FFC, 4'hF, 32'h0, 0, sc, ec, rv);
        check("oor_lo_data", rv, 32'h0);
        check("oor_lo_err", ec, 1);
        check("oor_lo_stall", sc, 4);
        access(0, 1, 32'h1000, 4'h0, 32'h0, 0, sc, ec, rv);
        check("rd3", rv, 32'hDEADBEAA);
        access(0, 1, 32'h2000, 4'hF, 32'h0, 0, sc, ec, rv);
        check("oor_hi_data", rv, 32'h0);
        check("oor_hi_err", ec, 1);
        check("oor_hi_stall", sc, 4);

        access(1, 0, 32'h1004, 4'hF, 32'h12345678, 1, sc, ec, rv);
        check("wr_scr_stall", sc, 4);
        access(0, 1, 32'h1004, 4'h0, 32'h0, 0, sc, ec, rv);
        check("rd_scr", rv, 32'h12345678);
        access(0, 1, 32'h1000, 4'h0, 32'h0, 0, sc, ec, rv);
        check("rd_scr_other", rv, 32'hDEADBEAA);

        access(1, 0, 32'h1004, 4'h0, 32'hFFFFFFFF, 0, sc, ec, rv);
        check("be0_stall", sc, 4);
        check("be0_err", ec, 0);
        access(0, 1, 32'h1004, 4'h0, 32'h0, 0, sc, ec, rv);
        check("be0_data", rv, 32'h12345678);

        access(1, 1, 32'h100C, 4'hF, 32'h55AA55AA, 0, sc, ec, rv);
        check("conf_err", ec, 1);
        check("conf_stall", sc, 4);
        check("conf_rdata", rv, 32'h12345678);
        access(0, 1, 32'h100C, 4'h0, 32'h0, 0, sc, ec, rv);
        check("conf_data", rv, 32'h55AA55AA);

        access(1, 0, 32'h2000, 4'hF, 32'h01020304, 0, sc, ec, rv);
        check("oor_wr_err", ec, 1);

        access(1, 0, 32'h1008, 4'hF, 32'h0, 0, sc, ec, rv);
        @(negedge clk);
        addr  = 32'h1008;
        wdata = 32'hFFFFFFFF;
        be    = 4'hF;
        wr    = 1'b1;
        @(negedge clk);
        #1;
        check("mid_busy", {31'd0, stall_a}, 32'd1);
        reset = 1'b1;
        #1;
        check("mid_rst_stall", {31'd0, stall_a}, 32'd0);
        check("mid_rst_rdata", rdata_a, 32'd0);
        check("mid_rst_err", {31'd0, err_a}, 32'd0);
        wr = 1'b0;
        @(negedge clk);
        #1;
        check("mid_rst_idle", {31'd0, stall_a}, 32'd0);
        reset = 1'b0;
        access(0, 1, 32'h1008, 4'h0, 32'h0, 0, sc, ec, rv);
        check("abort_data", rv, 32'h0);

        sel = 1'b1;
        access(1, 0, 32'h1000, 4'hF, 32'hCAFEF00D, 0, sc, ec, rv);
        check("w0_wr_stall", sc, 2);
        access(1, 0, 32'h1004, 4'hF, 32'h0BADC0DE, 0, sc, ec, rv);
        check("w0_wr2_stall", sc, 2);

        @(negedge clk);
        addr = 32'h1000;
        rd   = 1'b1;
        for (int i = 0; i < 6; i++) begin
            #1;
            check($sformatf("w0_b2b_stall%0d", i),
                  {31'd0, stall_b}, (i % 3 == 2) ? 32'd0 : 32'd1);
            if (i == 2) begin
                check("w0_b2b_rd1", rdata_b, 32'hCAFEF00D);
                addr = 32'h1004;
            end
            if (i == 5) begin
                check("w0_b2b_rd2", rdata_b, 32'h0BADC0DE);
            end
            @(negedge clk);
        end
        rd = 1'b0;
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
